// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package sseg_pkg;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry 0 is the rightmost element; listed F down to 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sseg_hexdec.sv
// Hex digit plus decimal point to active-low segment pattern.
// Output is {dp, g, f, e, d, c, b, a}.
module sseg_hexdec
  import sseg_pkg::*;
(
  input  digit_t      dig,
  output logic [7:0]  segs
);

  assign segs = {~dig.dp, SEG_LUT[dig.hex]};

endmodule

// File: rtl/sseg_scan.sv
// Multiplexed N-digit seven-segment scanner with double-buffered
// frame, ghosting guard and PWM brightness; active-low pin drive.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int DIV      = 50000,
  parameter int GUARD    = 64,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [BRIGHT_W-1:0]   bright_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [7:0]            digit_segs,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int QW = $clog2(N_DIGITS);

  logic [PW-1:0]       pre;
  logic [QW-1:0]       pos;
  logic [BRIGHT_W-1:0] duty;

  digit_t [N_DIGITS-1:0] pend_dig;
  digit_t [N_DIGITS-1:0] act_dig;
  logic [N_DIGITS-1:0]   pend_blank;
  logic [N_DIGITS-1:0]   act_blank;
  logic [BRIGHT_W-1:0]   pend_bright;
  logic [BRIGHT_W-1:0]   act_bright;

  logic                slot_end;
  logic                wrap;
  logic                lit;
  logic [7:0]          dec_segs;
  logic [N_DIGITS-1:0] sel_n;

  assign slot_end = enable && (pre == PW'(DIV - 1));
  assign wrap     = slot_end && (pos == QW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      pos  <= '0;
      duty <= '0;
    end else if (enable) begin
      duty <= duty + 1'b1;
      if (slot_end) begin
        pre <= '0;
        pos <= wrap ? '0 : pos + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // A load coinciding with the wrap bypasses pending straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig    <= '0;
      pend_blank  <= '1;
      pend_bright <= '0;
      act_dig     <= '0;
      act_blank   <= '1;
      act_bright  <= '0;
    end else begin
      if (load) begin
        pend_dig    <= digits_in;
        pend_blank  <= blank_in;
        pend_bright <= bright_in;
      end
      if (wrap) begin
        act_dig    <= load ? digits_in : pend_dig;
        act_blank  <= load ? blank_in  : pend_blank;
        act_bright <= load ? bright_in : pend_bright;
      end
    end
  end

  sseg_hexdec u_hexdec (
    .dig  (act_dig[pos]),
    .segs (dec_segs)
  );

  assign lit = enable
            && (pre >= PW'(GUARD))
            && !act_blank[pos]
            && (duty < act_bright);

  // Digit 0 sits on the MSB of the select bus.
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && (pos == QW'(N_DIGITS - 1 - i)))
        sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_segs <= SEG_OFF;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      digit_segs <= lit ? dec_segs : SEG_OFF;
      digit_sel  <= sel_n;
      frame_done <= wrap;
    end
  end

endmodule
